axilite_cfg_bridge: RTL and testbench
=====================================

Name:
axilite_cfg_bridge

Overview:
- AXI4-Lite slave that converts 32-bit bus word accesses into single-word accesses on a simple IP memory port (en/wen/addr/wdata, rack/rdata).
- Used to load and read back threshold parameters of the thresholding kernel.
- Supports IP words wider than the bus by splitting each IP word into ADDR_FOLD 32-bit slices.

Parameters:
- ADDR_WIDTH, 8: byte address width of AW/AR channels.
- DATA_WIDTH, 32: bus data width. Only 32 is supported.
- IP_DATA_WIDTH, 32: IP word width, 1 or more.
- Derived ADDR_FOLD = 1+(IP_DATA_WIDTH-1)/32.
- Derived FOLD_BITS = $clog2(ADDR_FOLD).
- Derived IP_ADDR_WIDTH = ADDR_WIDTH-2-FOLD_BITS.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- awvalid/awready  in/out  1  write address handshake.
- awaddr  in  ADDR_WIDTH  byte address.
- awprot  in  3  ignored.
- wvalid/wready  in/out  1  write data handshake.
- wdata  in  32  write data.
- wstrb  in  4  ignored; full-word writes.
- bvalid/bready  out/in  1  write response handshake.
- bresp  out  2  write response.
- arvalid/arready  in/out  1  read address handshake.
- araddr  in  ADDR_WIDTH  byte address.
- arprot  in  3  ignored.
- rvalid/rready  out/in  1  read data handshake.
- rdata  out  32  read data.
- rresp  out  2  read response.
- ip_en  out  1  one-cycle IP access strobe.
- ip_wen  out  1  1=write, 0=read; valid with ip_en.
- ip_addr  out  IP_ADDR_WIDTH  IP word address.
- ip_wdata  out  IP_DATA_WIDTH  IP write word.
- ip_rack  in  1  one-cycle strobe: ip_rdata valid.
- ip_rdata  in  IP_DATA_WIDTH  IP read word.

Behaviour:
- Reset: awready, wready, arready, bvalid, rvalid, ip_en = 0. bresp = rresp = 00. rdata = 0. Slice staging register = 0. FSM = IDLE.
- Address decode:
  - addr[1:0] ignored.
  - slice index s = addr[2+:FOLD_BITS], or 0 when FOLD_BITS = 0.
  - ip_addr = addr[ADDR_WIDTH-1 : 2+FOLD_BITS].
- FSM states: IDLE, WRITE, WRESP, READ, RWAIT, RRESP. Only one transaction is in flight at a time.
- IDLE, write:
  - When awvalid && wvalid, assert awready and wready together in that cycle T (combinational from the valids while in IDLE).
  - Latch address and data; go to WRITE.
  - awvalid without wvalid, or the reverse, is not accepted.
- Arbitration: writes have priority. arready = arvalid && IDLE && !(awvalid && wvalid).
- WRITE (cycle T+1):
  - Store wdata into staging slice s.
  - If s == ADDR_FOLD-1: ip_en=1, ip_wen=1, ip_wdata = assembled word (low IP_DATA_WIDTH bits of the concatenated slices, slice 0 least significant).
  - Otherwise no IP access (ip_en=0).
  - Go to WRESP.
- WRESP:
  - bvalid=1 from T+2, bresp=00. Hold until bready.
  - Return to IDLE in the cycle after the handshake.
- IDLE, read:
  - On arready && arvalid (cycle T), latch address; go to READ.
- READ (cycle T+1): ip_en=1, ip_wen=0, ip_addr driven; go to RWAIT.
- RWAIT:
  - Wait any number of cycles for ip_rack. Accept a rack from T+2 onward.
  - On rack, capture rdata = ip_rdata[32*s +: 32], with bits beyond IP_DATA_WIDTH zero-filled. Go to RRESP.
- RRESP:
  - rvalid=1 with rresp=00. rdata is held stable until rready.
  - IDLE next cycle.
- ip_en is never high for more than one cycle per transaction. ip_addr, ip_wdata and ip_wen are don't-care when ip_en=0.
- Back-to-back: a new request can be accepted in the cycle after the B or R handshake completes.
- rst mid-transaction aborts it: outputs return to reset values next cycle, no response is issued, and staging is cleared.
- Only OKAY (00) responses are produced.

Test Plan:
- Write awaddr=0x08, wdata=0x1234, IP_DATA_WIDTH=16 → one ip_en/ip_wen pulse with ip_addr=2, ip_wdata=0x1234; bvalid the following cycle; bresp=00.
- Read araddr=0x08, ip_rack 3 cycles after ip_en with ip_rdata=0x00AB → rvalid with rdata=0x000000AB, held while rready=0 for 4 cycles.
- IP_DATA_WIDTH=40:
  - Write slice 0 at 0x10 with 0xDEADBEEF → no ip_en; bvalid returned.
  - Write slice 1 at 0x14 with 0x7F → ip_en, ip_addr=2, ip_wdata=0x7FDEADBEEF.
  - Read 0x14 → rdata=0x0000007F.
- AW+W and AR valid in the same cycle → write accepted first, read accepted after the B handshake; exactly two ip_en pulses.
- AW valid alone for 5 cycles, then W → awready stays 0 until both are valid; one write is issued.
- Assert rst during RWAIT → rvalid never rises, ip_en=0, and the next read completes normally.

Source files
------------

// File: rtl/axilite_cfg_bridge.sv
// AXI4-Lite slave bridging 32-bit word accesses onto a single-word IP memory port.
// IP words wider than 32 bits are folded across consecutive bus addresses.
module axilite_cfg_bridge #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int IP_DATA_WIDTH = 32,
    localparam int ADDR_FOLD     = 1 + (IP_DATA_WIDTH - 1) / 32,
    localparam int FOLD_BITS     = $clog2(ADDR_FOLD),
    localparam int IP_ADDR_WIDTH = ADDR_WIDTH - 2 - FOLD_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic [2:0]               awprot,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [3:0]               wstrb,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic [2:0]               arprot,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     ip_en,
    output logic                     ip_wen,
    output logic [IP_ADDR_WIDTH-1:0] ip_addr,
    output logic [IP_DATA_WIDTH-1:0] ip_wdata,
    input  logic                     ip_rack,
    input  logic [IP_DATA_WIDTH-1:0] ip_rdata
);

    localparam int SW = (FOLD_BITS > 0) ? FOLD_BITS : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WRESP, S_READ, S_RWAIT, S_RRESP
    } state_e;

    state_e                       state_q, state_d;
    logic [ADDR_WIDTH-1:2]        addr_q;
    logic [31:0]                  wdata_q;
    logic [31:0]                  rdata_q;
    logic [ADDR_FOLD-1:0][31:0]   stage_q, stage_d;
    logic [ADDR_FOLD-1:0][31:0]   rd_slices;
    logic [ADDR_FOLD*32-1:0]      rd_pad;
    logic [ADDR_FOLD*32-1:0]      stage_flat;
    logic [SW-1:0]                slice;
    logic                         wr_take, rd_take;
    logic                         unused_ok;

    // Writes win when both channels present a request in the same idle cycle.
    assign wr_take = (state_q == S_IDLE) && awvalid && wvalid;
    assign rd_take = (state_q == S_IDLE) && arvalid && !(awvalid && wvalid);

    generate
        if (FOLD_BITS == 0) begin : g_nofold
            assign slice = '0;
        end else begin : g_fold
            assign slice = addr_q[2 +: FOLD_BITS];
        end
    endgenerate

    always_comb begin
        rd_pad                      = '0;
        rd_pad[IP_DATA_WIDTH-1:0]   = ip_rdata;
    end

    // The write word seen by the IP already contains the slice being written.
    generate
        for (genvar gi = 0; gi < ADDR_FOLD; gi++) begin : g_slice
            assign rd_slices[gi] = rd_pad[32*gi +: 32];
            assign stage_d[gi]   = (slice == SW'(gi)) ? wdata_q : stage_q[gi];
        end
    endgenerate

    assign stage_flat = stage_d;
    assign unused_ok  = ^{awprot, arprot, wstrb, awaddr[1:0], araddr[1:0], stage_flat};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_take) begin
                    state_d = S_WRITE;
                end else if (rd_take) begin
                    state_d = S_READ;
                end
            end
            S_WRITE: state_d = S_WRESP;
            S_WRESP: if (bready) state_d = S_IDLE;
            S_READ:  state_d = S_RWAIT;
            S_RWAIT: if (ip_rack) state_d = S_RRESP;
            S_RRESP: if (rready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        awready  = wr_take;
        wready   = wr_take;
        arready  = rd_take;
        bvalid   = (state_q == S_WRESP);
        rvalid   = (state_q == S_RRESP);
        bresp    = 2'b00;
        rresp    = 2'b00;
        rdata    = rdata_q;
        ip_en    = ((state_q == S_WRITE) && (slice == SW'(ADDR_FOLD - 1))) ||
                   (state_q == S_READ);
        ip_wen   = (state_q == S_WRITE);
        ip_addr  = addr_q[ADDR_WIDTH-1 -: IP_ADDR_WIDTH];
        ip_wdata = stage_flat[IP_DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            stage_q <= '0;
            rdata_q <= '0;
        end else begin
            if (wr_take) begin
                addr_q  <= awaddr[ADDR_WIDTH-1:2];
                wdata_q <= wdata;
            end else if (rd_take) begin
                addr_q  <= araddr[ADDR_WIDTH-1:2];
            end
            if (state_q == S_WRITE) begin
                stage_q <= stage_d;
            end
            // A rack arriving while still in READ is not a valid completion.
            if ((state_q == S_RWAIT) && ip_rack) begin
                rdata_q <= rd_slices[slice];
            end
        end
    end

endmodule

// File: tb/tb_axilite_cfg_bridge.sv
// Scoreboard bench for axilite_cfg_bridge: one 16-bit and one 40-bit IP instance
// share a bus master; dsel routes the master to the instance under test.
module tb_axilite_cfg_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        dsel;
    logic        awvalid, wvalid, arvalid, bready, rready, ip_rack;
    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic [39:0] ip_rdata;

    logic aw16, w16, ar16, rk16, aw40, w40, ar40, rk40;
    assign aw16 = awvalid & ~dsel;  assign aw40 = awvalid & dsel;
    assign w16  = wvalid  & ~dsel;  assign w40  = wvalid  & dsel;
    assign ar16 = arvalid & ~dsel;  assign ar40 = arvalid & dsel;
    assign rk16 = ip_rack & ~dsel;  assign rk40 = ip_rack & dsel;

    logic        awready16, wready16, bvalid16, arready16, rvalid16, ip_en16, ip_wen16;
    logic [1:0]  bresp16, rresp16;
    logic [31:0] rdata16;
    logic [5:0]  ip_addr16;
    logic [15:0] ip_wdata16;
    logic        awready40, wready40, bvalid40, arready40, rvalid40, ip_en40, ip_wen40;
    logic [1:0]  bresp40, rresp40;
    logic [31:0] rdata40;
    logic [4:0]  ip_addr40;
    logic [39:0] ip_wdata40;

    axilite_cfg_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .IP_DATA_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .awvalid(aw16), .awready(awready16), .awaddr(awaddr), .awprot(3'b000),
        .wvalid(w16), .wready(wready16), .wdata(wdata), .wstrb(4'hF),
        .bvalid(bvalid16), .bready(bready), .bresp(bresp16),
        .arvalid(ar16), .arready(arready16), .araddr(araddr), .arprot(3'b000),
        .rvalid(rvalid16), .rready(rready), .rdata(rdata16), .rresp(rresp16),
        .ip_en(ip_en16), .ip_wen(ip_wen16), .ip_addr(ip_addr16), .ip_wdata(ip_wdata16),
        .ip_rack(rk16), .ip_rdata(ip_rdata[15:0])
    );

    axilite_cfg_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .IP_DATA_WIDTH(40)) u_dut40 (
        .clk(clk), .rst(rst),
        .awvalid(aw40), .awready(awready40), .awaddr(awaddr), .awprot(3'b000),
        .wvalid(w40), .wready(wready40), .wdata(wdata), .wstrb(4'hF),
        .bvalid(bvalid40), .bready(bready), .bresp(bresp40),
        .arvalid(ar40), .arready(arready40), .araddr(araddr), .arprot(3'b000),
        .rvalid(rvalid40), .rready(rready), .rdata(rdata40), .rresp(rresp40),
        .ip_en(ip_en40), .ip_wen(ip_wen40), .ip_addr(ip_addr40), .ip_wdata(ip_wdata40),
        .ip_rack(rk40), .ip_rdata(ip_rdata)
    );

    logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m, ip_en_m, ip_wen_m;
    logic [1:0]  bresp_m, rresp_m;
    logic [31:0] rdata_m;
    logic [5:0]  ip_addr_m;
    logic [39:0] ip_wdata_m;
    assign awready_m  = dsel ? awready40 : awready16;
    assign wready_m   = dsel ? wready40  : wready16;
    assign bvalid_m   = dsel ? bvalid40  : bvalid16;
    assign arready_m  = dsel ? arready40 : arready16;
    assign rvalid_m   = dsel ? rvalid40  : rvalid16;
    assign ip_en_m    = dsel ? ip_en40   : ip_en16;
    assign ip_wen_m   = dsel ? ip_wen40  : ip_wen16;
    assign bresp_m    = dsel ? bresp40   : bresp16;
    assign rresp_m    = dsel ? rresp40   : rresp16;
    assign rdata_m    = dsel ? rdata40   : rdata16;
    assign ip_addr_m  = dsel ? {1'b0, ip_addr40} : ip_addr16;
    assign ip_wdata_m = dsel ? ip_wdata40 : {24'h0, ip_wdata16};

    typedef struct { logic wen; logic [5:0] addr; logic [39:0] wdata; } ip_exp_t;
    typedef struct { logic is_rd; logic [31:0] data; } rsp_exp_t;
    ip_exp_t  ip_q[$];
    rsp_exp_t rsp_q[$];
    ip_exp_t  mon_ip;
    rsp_exp_t mon_rsp;

    int n_cmp = 0;
    int n_err = 0;
    int ip_en_cnt = 0;
    int gen = 0;
    int rack_delay = 3;
    logic [39:0] rd_word = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_ip(input logic wen, input logic [5:0] a, input logic [39:0] d);
        ip_exp_t e;
        e.wen = wen; e.addr = a; e.wdata = d;
        ip_q.push_back(e);
    endtask

    task automatic push_rsp(input logic is_rd, input logic [31:0] d);
        rsp_exp_t e;
        e.is_rd = is_rd; e.data = d;
        rsp_q.push_back(e);
    endtask

    // Monitor: samples 2 time units after the falling edge, after all drivers settle.
    initial forever begin
        @(negedge clk); #2;
        if (!rst) begin
            if (ip_en_m) begin
                ip_en_cnt++;
                if (ip_q.size() == 0) check_val("ip_en_unexpected", 1, 0);
                else begin
                    mon_ip = ip_q.pop_front();
                    $display("[%0t] ip %s addr=%0d data=0x%0h", $time, ip_wen_m ? "wr" : "rd",
                             ip_addr_m, ip_wdata_m);
                    check_val("ip_wen", ip_wen_m, mon_ip.wen);
                    check_val("ip_addr", ip_addr_m, mon_ip.addr);
                    if (mon_ip.wen) check_val("ip_wdata", ip_wdata_m, mon_ip.wdata);
                end
            end
            if (bvalid_m && bready) begin
                $display("[%0t] B resp=%0d", $time, bresp_m);
                if (rsp_q.size() == 0) check_val("b_unexpected", 1, 0);
                else begin
                    mon_rsp = rsp_q.pop_front();
                    check_val("b_kind", mon_rsp.is_rd, 0);
                    check_val("bresp", bresp_m, 2'b00);
                end
            end
            if (rvalid_m && rready) begin
                $display("[%0t] R data=0x%08h resp=%0d", $time, rdata_m, rresp_m);
                if (rsp_q.size() == 0) check_val("r_unexpected", 1, 0);
                else begin
                    mon_rsp = rsp_q.pop_front();
                    check_val("r_kind", mon_rsp.is_rd, 1);
                    check_val("rdata", rdata_m, mon_rsp.data);
                    check_val("rresp", rresp_m, 2'b00);
                end
            end
        end
    end

    // IP read responder: rack rack_delay cycles after a read strobe, dropped on reset.
    initial forever begin
        @(negedge clk); #2;
        if (!rst && ip_en_m && !ip_wen_m) begin
            automatic int g = gen;
            repeat (rack_delay) @(negedge clk);
            if (g == gen) begin
                ip_rack  = 1'b1;
                ip_rdata = rd_word;
                @(negedge clk);
                ip_rack  = 1'b0;
                ip_rdata = {8'($urandom()), $urandom()};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; #1;
        for (int k = 0; k < 20 && !(awready_m && wready_m); k++) begin
            @(negedge clk); #1;
        end
        check_val("aw_w_accept", {awready_m, wready_m}, 2'b11);
        @(posedge clk); @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; #1;
        check_val("bvalid_T1", bvalid_m, 0);
        @(negedge clk); #1;
        check_val("bvalid_T2", bvalid_m, 1);
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic do_read(input logic [7:0] a, input int hold, input logic [31:0] exp);
        rready = (hold == 0); araddr = a; arvalid = 1'b1; #1;
        for (int k = 0; k < 20 && !arready_m; k++) begin
            @(negedge clk); #1;
        end
        check_val("ar_accept", arready_m, 1);
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0; #1;
        for (int k = 0; k < 30 && !rvalid_m; k++) begin
            @(negedge clk); #1;
        end
        check_val("rvalid_seen", rvalid_m, 1);
        for (int i = 0; i < hold; i++) begin
            check_val("r_hold_valid", rvalid_m, 1);
            check_val("r_hold_data", rdata_m, exp);
            @(negedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        check_val("rvalid_drop", rvalid_m, 0);
    endtask

    initial begin
        int cnt0;
        rst = 1'b1; dsel = 1'b0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1; ip_rack = 0;
        awaddr = '0; araddr = '0; wdata = '0; ip_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_valids16", {awready16, wready16, arready16, bvalid16, rvalid16, ip_en16}, 0);
        check_val("rst_valids40", {awready40, wready40, arready40, bvalid40, rvalid40, ip_en40}, 0);
        check_val("rst_resp_data16", {bresp16, rresp16, rdata16}, 0);
        check_val("rst_resp_data40", {bresp40, rresp40, rdata40}, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        // 16-bit IP: single write and a read held under backpressure
        push_ip(1, 6'd2, 40'h1234); push_rsp(0, 0);
        do_write(8'h08, 32'h0000_1234);
        rd_word = 40'h00AB; rack_delay = 3;
        push_ip(0, 6'd2, 0); push_rsp(1, 32'h0000_00AB);
        do_read(8'h08, 4, 32'h0000_00AB);

        // Simultaneous write and read: write first, read after the B handshake
        cnt0 = ip_en_cnt;
        rd_word = 40'hFF_FFFF_5A5A;
        push_ip(1, 6'd3, 40'hBEEF); push_rsp(0, 0);
        push_ip(0, 6'd15, 0);       push_rsp(1, 32'h0000_5A5A);
        awaddr = 8'h0C; wdata = 32'h0000_BEEF; araddr = 8'h3C;
        awvalid = 1; wvalid = 1; arvalid = 1; #1;
        check_val("both_awready", awready_m, 1);
        check_val("both_arready_blocked", arready_m, 0);
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0; #1;
        check_val("ar_blocked_write", arready_m, 0);
        @(negedge clk); #1;
        check_val("ar_blocked_wresp", arready_m, 0);
        @(negedge clk); #1;
        check_val("ar_after_b", arready_m, 1);
        @(posedge clk); @(negedge clk);
        arvalid = 0; #1;
        for (int k = 0; k < 30 && !rvalid_m; k++) begin
            @(negedge clk); #1;
        end
        check_val("both_rvalid", rvalid_m, 1);
        @(posedge clk); @(negedge clk); #1;
        check_val("both_two_ip_en", ip_en_cnt - cnt0, 2);

        // AW alone is not accepted until W joins it
        cnt0 = ip_en_cnt;
        push_ip(1, 6'd5, 40'h0F0F); push_rsp(0, 0);
        awaddr = 8'h14; awvalid = 1; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("aw_alone_ready", {awready_m, wready_m}, 2'b00);
            @(negedge clk);
        end
        do_write(8'h14, 32'h0000_0F0F);
        check_val("aw_alone_one_ip_en", ip_en_cnt - cnt0, 1);

        // 40-bit IP: two slices per word
        dsel = 1'b1;
        cnt0 = ip_en_cnt;
        push_rsp(0, 0);
        do_write(8'h10, 32'hDEAD_BEEF);
        check_val("slice0_no_ip_en", ip_en_cnt - cnt0, 0);
        push_ip(1, 6'd2, 40'h7F_DEAD_BEEF); push_rsp(0, 0);
        do_write(8'h14, 32'h0000_007F);
        rd_word = 40'h7F_DEAD_BEEF; rack_delay = 1;
        push_ip(0, 6'd2, 0); push_rsp(1, 32'h0000_007F);
        do_read(8'h14, 0, 32'h0000_007F);
        push_ip(0, 6'd2, 0); push_rsp(1, 32'hDEAD_BEEF);
        do_read(8'h10, 2, 32'hDEAD_BEEF);

        // Reset while waiting for rack aborts the read and clears staging
        rack_delay = 6;
        push_ip(0, 6'd3, 0);
        araddr = 8'h18; arvalid = 1; #1;
        check_val("abort_ar_accept", arready_m, 1);
        @(posedge clk); @(negedge clk);
        arvalid = 0;
        @(negedge clk);
        rst = 1'b1; gen++;
        @(negedge clk); #1;
        check_val("abort_rvalid", rvalid_m, 0);
        check_val("abort_ip_en", ip_en_m, 0);
        check_val("abort_rdata", rdata_m, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            check_val("abort_quiet", {rvalid_m, bvalid_m, ip_en_m}, 3'b000);
        end
        push_ip(1, 6'd3, 40'h22_0000_0000); push_rsp(0, 0);
        do_write(8'h1C, 32'h0000_0022);
        rd_word = 40'h22_1234_5678; rack_delay = 2;
        push_ip(0, 6'd3, 0); push_rsp(1, 32'h1234_5678);
        do_read(8'h18, 0, 32'h1234_5678);

        repeat (3) @(negedge clk);
        check_val("ip_queue_drained", ip_q.size(), 0);
        check_val("rsp_queue_drained", rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
